// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared constants for the two-master Bridge bus arbiter:
//   ARB_M0 / ARB_M1 : master index encodings used by last_gnt and rd_owner
//   ARB_BUS_W       : Bridge address/data width
//   ARB_WAIT_W      : width of the master-1 aging counter
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

  localparam logic ARB_M0     = 1'b0;
  localparam logic ARB_M1     = 1'b1;
  localparam int   ARB_BUS_W  = 32;
  localparam int   ARB_WAIT_W = 4;

endpackage : bus_arbiter_pkg

// File: rtl/bus_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational winner select for the two-master arbiter.
// Build option: ROUND_ROBIN_EN selects alternating priority on contention;
// otherwise master 0 has fixed priority unless force_m1_i ages master 1 in.
// Ports:
//   req0_i, req1_i  : master requests
//   last_gnt_i      : index of the most recently granted master
//   force_m1_i      : master 1 aged out (fixed-priority build only)
//   gnt0_o, gnt1_o  : one-hot (or zero) grant
// -----------------------------------------------------------------------------
module arb_pick
  import bus_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_gnt_i,
  input  logic force_m1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic unused_s;

`ifdef ROUND_ROBIN_EN
  // Aging is not used when priority alternates.
  assign unused_s = force_m1_i;

  // Round-robin select: on contention the master that did not win last time wins.
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (req0_i && req1_i) begin
      if (last_gnt_i == ARB_M0) begin
        gnt1_o = 1'b1;
      end else begin
        gnt0_o = 1'b1;
      end
    end else if (req0_i) begin
      gnt0_o = 1'b1;
    end else if (req1_i) begin
      gnt1_o = 1'b1;
    end else begin
      gnt0_o = 1'b0;
      gnt1_o = 1'b0;
    end
  end
`else
  // History is tracked by the top but does not steer fixed priority.
  assign unused_s = last_gnt_i;

  // Fixed-priority select: master 0 wins unless master 1 has aged out.
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (force_m1_i && req1_i) begin
      gnt1_o = 1'b1;
    end else if (req0_i) begin
      gnt0_o = 1'b1;
    end else if (req1_i) begin
      gnt1_o = 1'b1;
    end else begin
      gnt0_o = 1'b0;
      gnt1_o = 1'b0;
    end
  end
`endif

endmodule : arb_pick

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Shares the Bridge data bus between the MEM stage (master 0) and a secondary
// master (master 1). One single-beat transaction per cycle; read data returns
// one cycle after the grant and is steered to the owning master.
// Build option: ROUND_ROBIN_EN (alternating priority, aging disabled);
// default build is fixed priority with MAX_WAIT aging for master 1.
// Ports:
//   cpu_clk, cpu_rst               : clock, synchronous active-high reset
//   mN_req/wen/addr/wdata          : master requests, held until granted
//   mN_gnt                         : combinational grant
//   mN_rvalid/mN_rdata             : read return, one cycle after grant
//   m0_stall                       : MEM stage denied, to hazard unit
//   Bus_addr/Bus_wen/Bus_wdata     : to Bridge (zero when idle)
//   Bus_rdata                      : from Bridge, one cycle after read address
// -----------------------------------------------------------------------------
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rst,
  input  logic                 m0_req,
  input  logic                 m0_wen,
  input  logic [ARB_BUS_W-1:0] m0_addr,
  input  logic [ARB_BUS_W-1:0] m0_wdata,
  input  logic                 m1_req,
  input  logic                 m1_wen,
  input  logic [ARB_BUS_W-1:0] m1_addr,
  input  logic [ARB_BUS_W-1:0] m1_wdata,
  output logic                 m0_gnt,
  output logic                 m1_gnt,
  output logic                 m0_rvalid,
  output logic                 m1_rvalid,
  output logic [ARB_BUS_W-1:0] m0_rdata,
  output logic [ARB_BUS_W-1:0] m1_rdata,
  output logic                 m0_stall,
  output logic [ARB_BUS_W-1:0] Bus_addr,
  output logic                 Bus_wen,
  output logic [ARB_BUS_W-1:0] Bus_wdata,
  input  logic [ARB_BUS_W-1:0] Bus_rdata
);

  localparam logic [ARB_WAIT_W-1:0] MAX_WAIT_C = ARB_WAIT_W'(MAX_WAIT);

  logic                  rd_pend_q,  rd_pend_d;
  logic                  rd_owner_q, rd_owner_d;
  logic                  last_gnt_q, last_gnt_d;
  logic [ARB_WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  force_m1_s;

  // Aging only fires while master 1 is still asking; a withdrawn request
  // at the limit lets master 0 proceed normally.
  assign force_m1_s = m1_req && (wait_cnt_q == MAX_WAIT_C);

  arb_pick u_pick (
    .req0_i     (m0_req),
    .req1_i     (m1_req),
    .last_gnt_i (last_gnt_q),
    .force_m1_i (force_m1_s),
    .gnt0_o     (m0_gnt),
    .gnt1_o     (m1_gnt)
  );

  assign m0_stall = m0_req & ~m0_gnt;

  // Read return: rvalid comes straight from the pending flag; reset in the
  // return cycle discards the read so no stale data reaches the owner.
  assign m0_rvalid = rd_pend_q & ~cpu_rst & (rd_owner_q == ARB_M0);
  assign m1_rvalid = rd_pend_q & ~cpu_rst & (rd_owner_q == ARB_M1);
  assign m0_rdata  = m0_rvalid ? Bus_rdata : 32'h0000_0000;
  assign m1_rdata  = m1_rvalid ? Bus_rdata : 32'h0000_0000;

  // Bus output mux: winner's request, all zeros on an idle cycle.
  always_comb begin
    Bus_addr  = 32'h0000_0000;
    Bus_wen   = 1'b0;
    Bus_wdata = 32'h0000_0000;
    case ({m1_gnt, m0_gnt})
      2'b01: begin
        Bus_addr  = m0_addr;
        Bus_wen   = m0_wen;
        Bus_wdata = m0_wdata;
      end
      2'b10: begin
        Bus_addr  = m1_addr;
        Bus_wen   = m1_wen;
        Bus_wdata = m1_wdata;
      end
      default: begin
        Bus_addr  = 32'h0000_0000;
        Bus_wen   = 1'b0;
        Bus_wdata = 32'h0000_0000;
      end
    endcase
  end

  // Next-state for return tracking, grant history and master-1 aging.
  always_comb begin
    rd_pend_d  = (m0_gnt & ~m0_wen) | (m1_gnt & ~m1_wen);
    rd_owner_d = rd_owner_q;
    last_gnt_d = last_gnt_q;
    wait_cnt_d = {ARB_WAIT_W{1'b0}};
    if (m1_gnt) begin
      last_gnt_d = ARB_M1;
      rd_owner_d = rd_pend_d ? ARB_M1 : rd_owner_q;
    end else if (m0_gnt) begin
      last_gnt_d = ARB_M0;
      rd_owner_d = rd_pend_d ? ARB_M0 : rd_owner_q;
    end else begin
      last_gnt_d = last_gnt_q;
      rd_owner_d = rd_owner_q;
    end
`ifdef ROUND_ROBIN_EN
    wait_cnt_d = {ARB_WAIT_W{1'b0}};
`else
    if (m1_req && !m1_gnt) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_d = {ARB_WAIT_W{1'b0}};
    end
`endif
  end

  // State register; last_gnt resets to master 1 so master 0 wins the first tie.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= ARB_M0;
      last_gnt_q <= ARB_M1;
      wait_cnt_q <= {ARB_WAIT_W{1'b0}};
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      last_gnt_q <= last_gnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed self-checking bench for bus_arbiter (MAX_WAIT = 4). Inputs change
// 1 ns after the rising edge, outputs are checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        m0_req, m0_wen, m1_req, m1_wen;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_stall;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] Bus_addr, Bus_wdata, Bus_rdata;
  logic        Bus_wen;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bus_arbiter #(.MAX_WAIT(4)) dut (
    .cpu_clk  (cpu_clk),   .cpu_rst  (cpu_rst),
    .m0_req   (m0_req),    .m0_wen   (m0_wen),
    .m0_addr  (m0_addr),   .m0_wdata (m0_wdata),
    .m1_req   (m1_req),    .m1_wen   (m1_wen),
    .m1_addr  (m1_addr),   .m1_wdata (m1_wdata),
    .m0_gnt   (m0_gnt),    .m1_gnt   (m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata (m0_rdata),  .m1_rdata (m1_rdata),
    .m0_stall (m0_stall),
    .Bus_addr (Bus_addr),  .Bus_wen  (Bus_wen),
    .Bus_wdata(Bus_wdata), .Bus_rdata(Bus_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one cycle, leaving time for new inputs before the next check.
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_wen = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_wen = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
  endtask

  initial begin
    logic [9:0] exp_m1;
    cpu_rst = 1'b1;
    Bus_rdata = 32'h0;
    idle_inputs();
    tick(); tick();
    cpu_rst = 1'b0;
    settle();

    // Reset then idle
    check("rst_bus_wen",   {31'h0, Bus_wen},   32'h0);
    check("rst_bus_addr",  Bus_addr,           32'h0);
    check("rst_bus_wdata", Bus_wdata,          32'h0);
    check("rst_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
    check("rst_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
    check("rst_m0_rdata",  m0_rdata,           32'h0);
    check("rst_m0_stall",  {31'h0, m0_stall},  32'h0);
    check("rst_gnts",      {30'h0, m1_gnt, m0_gnt}, 32'h0);

    // m0 read of 0x100, data returns next cycle
    tick();
    m0_req = 1'b1; m0_wen = 1'b0; m0_addr = 32'h0000_0100;
    settle();
    check("rd_m0_gnt",   {31'h0, m0_gnt}, 32'h1);
    check("rd_m1_gnt",   {31'h0, m1_gnt}, 32'h0);
    check("rd_bus_addr", Bus_addr,        32'h0000_0100);
    check("rd_bus_wen",  {31'h0, Bus_wen}, 32'h0);
    tick();
    m0_req = 1'b0; Bus_rdata = 32'hDEAD_BEEF;
    settle();
    check("rd_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    check("rd_m0_rdata",  m0_rdata,           32'hDEAD_BEEF);
    check("rd_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
    check("rd_m1_rdata",  m1_rdata,           32'h0);
    check("rd_idle_addr", Bus_addr,           32'h0);
    tick();
    check("rd_after_rvalid", {31'h0, m0_rvalid}, 32'h0);

    // Back-to-back: m0 read then m1 write 0x10 := 0x55 in the return cycle
    m0_req = 1'b1; m0_wen = 1'b0; m0_addr = 32'h0000_0200;
    settle();
    check("b2b_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    tick();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_wen = 1'b1; m1_addr = 32'h0000_0010; m1_wdata = 32'h0000_0055;
    Bus_rdata = 32'h1234_5678;
    settle();
    check("b2b_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    check("b2b_m0_rdata",  m0_rdata,           32'h1234_5678);
    check("b2b_m1_gnt",    {31'h0, m1_gnt},    32'h1);
    check("b2b_bus_wen",   {31'h0, Bus_wen},   32'h1);
    check("b2b_bus_addr",  Bus_addr,           32'h0000_0010);
    check("b2b_bus_wdata", Bus_wdata,          32'h0000_0055);
    tick();
    idle_inputs();
    settle();
    check("b2b_wr_no_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);

    // Fresh reset, then both masters request writes continuously
    cpu_rst = 1'b1;
    tick();
    cpu_rst = 1'b0;
    m0_req = 1'b1; m0_wen = 1'b1; m0_addr = 32'h0000_0300; m0_wdata = 32'h0000_00A0;
    m1_req = 1'b1; m1_wen = 1'b1; m1_addr = 32'h0000_0400; m1_wdata = 32'h0000_00B1;
`ifdef ROUND_ROBIN_EN
    exp_m1 = 10'b10_1010_1010;
`else
    exp_m1 = 10'b10_0001_0000;
`endif
    for (int i = 0; i < 10; i++) begin
      settle();
      check($sformatf("both_m1_gnt_%0d", i),   {31'h0, m1_gnt},   {31'h0, exp_m1[i]});
      check($sformatf("both_m0_gnt_%0d", i),   {31'h0, m0_gnt},   {31'h0, ~exp_m1[i]});
      check($sformatf("both_stall_%0d", i),    {31'h0, m0_stall}, {31'h0, exp_m1[i]});
      check($sformatf("both_addr_%0d", i),     Bus_addr,
            exp_m1[i] ? 32'h0000_0400 : 32'h0000_0300);
      tick();
    end
    idle_inputs();
    settle();

`ifndef ROUND_ROBIN_EN
    // m1 withdraws after 3 waits: aging restarts from zero
    m0_req = 1'b1; m0_wen = 1'b1; m1_req = 1'b1; m1_wen = 1'b1;
    tick(); tick(); tick();
    m1_req = 1'b0;
    settle();
    check("wd_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    tick();
    m1_req = 1'b1;
    exp_m1 = 10'b00_0001_0000;
    for (int j = 0; j < 9; j++) begin
      settle();
      check($sformatf("wd_m1_gnt_%0d", j), {31'h0, m1_gnt}, {31'h0, exp_m1[j]});
      tick();
    end
    // wait_cnt is now 4; m1 drops in that cycle -> no forced grant
    m1_req = 1'b0;
    settle();
    check("maxdrop_m0_gnt", {31'h0, m0_gnt},   32'h1);
    check("maxdrop_m1_gnt", {31'h0, m1_gnt},   32'h0);
    check("maxdrop_stall",  {31'h0, m0_stall}, 32'h0);
    tick();
    m1_req = 1'b1;
    settle();
    check("maxdrop_cleared", {31'h0, m1_gnt}, 32'h0);
    tick();
    idle_inputs();
    settle();
`else
    // A single requester always wins, even if it won last time
    m1_req = 1'b1; m1_wen = 1'b1;
    settle();
    check("rr_single_1", {31'h0, m1_gnt}, 32'h1);
    tick();
    settle();
    check("rr_single_2", {31'h0, m1_gnt}, 32'h1);
    tick();
    idle_inputs();
    settle();
`endif

    // Reset in the cycle after an m1 read grant discards the read
    m1_req = 1'b1; m1_wen = 1'b0; m1_addr = 32'h0000_0500;
    settle();
    check("rstrd_m1_gnt", {31'h0, m1_gnt}, 32'h1);
    tick();
    m1_req = 1'b0; cpu_rst = 1'b1; Bus_rdata = 32'hCAFE_F00D;
    settle();
    check("rstrd_m1_rvalid_in_rst", {31'h0, m1_rvalid}, 32'h0);
    check("rstrd_m1_rdata_in_rst",  m1_rdata,           32'h0);
    tick();
    cpu_rst = 1'b0;
    settle();
    check("rstrd_rvalid_after", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
    // After reset both request: m0 must win (last_gnt / wait_cnt back to reset)
    m0_req = 1'b1; m0_wen = 1'b1; m1_req = 1'b1; m1_wen = 1'b1;
    settle();
    check("rstrd_first_m0", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    tick();
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_bus_arbiter
